// File: rtl/my_flip_flop_pkg.sv
// Shared constants for the my_flip_flop register path.
// The synchronizer depth only takes effect when MY_FLIP_FLOP_SYNC_EN is defined.
package my_flip_flop_pkg;

  localparam int   MY_FLIP_FLOP_WIDTH_DEF   = 1;
  localparam int   MY_FLIP_FLOP_SYNC_STAGES = 2;
  localparam logic MY_FLIP_FLOP_RESET_BIT   = 1'b0;

endpackage

// File: rtl/my_dff_ar.sv
// WIDTH-bit D register with asynchronous active-high reset to RESET_VALUE.
module my_dff_ar #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on each rising edge; reset wins immediately and holds while high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/my_flip_flop.sv
// Registered key-to-LED path; defining MY_FLIP_FLOP_SYNC_EN inserts a
// two-stage input synchronizer in front of the output register.
module my_flip_flop
  import my_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = MY_FLIP_FLOP_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{MY_FLIP_FLOP_RESET_BIT}}
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] key_input,
  output logic [WIDTH-1:0] led_out
);

  logic [WIDTH-1:0] out_d_s;

`ifdef MY_FLIP_FLOP_SYNC_EN
  logic [WIDTH-1:0] sync_s [MY_FLIP_FLOP_SYNC_STAGES+1];

  assign sync_s[0] = key_input;

  // Every stage resets with the output register so no stale bit survives reset.
  for (genvar i = 0; i < MY_FLIP_FLOP_SYNC_STAGES; i++) begin : g_sync
    my_dff_ar #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk (sys_clk),
      .rst (sys_rst),
      .d   (sync_s[i]),
      .q   (sync_s[i+1])
    );
  end

  assign out_d_s = sync_s[MY_FLIP_FLOP_SYNC_STAGES];
`else
  assign out_d_s = key_input;
`endif

  my_dff_ar #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_out (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (out_d_s),
    .q   (led_out)
  );

endmodule

// File: tb/tb_my_flip_flop.sv
// Self-checking bench for my_flip_flop: delay-line reference model plus
// directed literal checks and a random stream.
module tb_my_flip_flop;

  localparam int W = 1;
`ifdef MY_FLIP_FLOP_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         sys_clk;
  logic         sys_rst;
  logic [W-1:0] key_input;
  logic [W-1:0] led_out;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] key_seen;
  logic [W-1:0] hist[$];
  int           highs;

  my_flip_flop dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_input (key_input),
    .led_out   (led_out)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t led_out=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Inputs only change between a rising edge and the following falling edge,
  // so the level seen at the falling edge is the one the next rising edge takes.
  always @(negedge sys_clk) key_seen <= key_input;

  // Reference: output equals the key level taken LAT captures ago; reset empties the line.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back('0);
    end else begin
      hist.push_back(key_seen);
      void'(hist.pop_front());
    end
  end

  always @(negedge sys_clk) begin
    check("cycle_cmp", led_out, sys_rst ? '0 : hist[0]);
  end

  initial begin
    for (int i = 0; i < LAT; i++) hist.push_back('0);
    sys_rst   = 1'b1;
    key_input = '0;
    #1;
    check("reset_async_start", led_out, '0);
    #20;
    sys_rst = 1'b0;
    #4;
    check("no_capture_before_edge", led_out, '0);

    // basic capture of 1 then 0
    @(posedge sys_clk); #5;
    key_input = 1'b1;
    repeat (LAT) @(posedge sys_clk);
    #1;
    check("capture_one", led_out, 1'b1);
    #4;
    key_input = 1'b0;
    repeat (LAT) @(posedge sys_clk);
    #1;
    check("capture_zero", led_out, 1'b0);

    // edge-coincident change
    #4;
    key_input = 1'b1;
    repeat (LAT + 1) @(posedge sys_clk);
    key_input <= 1'b0;  // same time step as the edge, after the register has sampled
    repeat (LAT - 1) @(posedge sys_clk);
    #1;
    check("coincident_old", led_out, 1'b1);
    @(posedge sys_clk); #1;
    check("coincident_new", led_out, 1'b0);

    // mid-run asynchronous reset
    #4;
    key_input = 1'b1;
    repeat (LAT) @(posedge sys_clk);
    #1;
    check("pre_reset_high", led_out, 1'b1);
    #4;
    sys_rst = 1'b1;
    #1;
    check("reset_async_mid", led_out, 1'b0);
    #40;
    sys_rst = 1'b0;
    #2;
    check("reset_release_hold", led_out, 1'b0);
    repeat (LAT) @(posedge sys_clk);
    #1;
    check("post_reset_capture", led_out, 1'b1);

    // single-cycle pulse appears exactly once, LAT edges after it is taken
    #4;
    key_input = 1'b0;
    repeat (LAT + 1) @(posedge sys_clk);
    #5;
    key_input = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge sys_clk); #1;
      check("pulse_shape", led_out, (k == LAT - 1) ? 1'b1 : 1'b0);
      if (k == 0) begin
        #4;
        key_input = 1'b0;
      end
    end

    // reset while a pulse is in flight
    #4;
    key_input = 1'b1;
    highs = 0;
    @(posedge sys_clk); #1;
    if (led_out == 1'b1) highs++;
    #4;
    key_input = 1'b0;
    #1;
    sys_rst = 1'b1;
    #40;
    sys_rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge sys_clk); #1;
      if (led_out == 1'b1) highs++;
    end
    tests++;
    if (highs != ((LAT == 1) ? 1 : 0)) begin
      fails++;
      $display("FAIL pulse_flushed highs=%0d expected=%0d", highs, (LAT == 1) ? 1 : 0);
    end

    // random stream, checked per cycle by the model
    for (int n = 0; n < 220; n++) begin
      @(posedge sys_clk); #5;
      key_input = W'($urandom);
    end
    repeat (LAT + 2) @(posedge sys_clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
